// File: rtl/button_pkg.sv
// Shared defaults and helpers for the push-button conditioning block.
package button_pkg;

    localparam int BTN_WIDTH_DEF      = 8;
    localparam int BTN_CNT_MAX_DEF    = 250000;
    localparam int BTN_ACTIVE_LOW_DEF = 1;

    function automatic int cnt_w(input int max);
        return $clog2(max);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button: two-flop synchroniser, polarity normalisation, stability counter,
// debounced level and registered press/release pulses.
module debounce_bit
    import button_pkg::*;
#(
    parameter int CNT_MAX    = BTN_CNT_MAX_DEF,
    parameter int ACTIVE_LOW = BTN_ACTIVE_LOW_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_db,
    output logic btn_press,
    output logic btn_release
);

    localparam int              CW       = cnt_w(CNT_MAX);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CNT_MAX - 1);
    // Pad level of a button that is not being pushed.
    localparam logic            REL_LVL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q, db_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s_s;

    assign s_s = sync2_q ^ REL_LVL;

    // Next-state: synchroniser shift, stability count and level acceptance.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        db_d      = db_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s_s == db_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            db_d      = s_s;
            cnt_d     = {CW{1'b0}};
            press_d   = s_s;
            release_d = ~s_s;
        end else begin
            cnt_d = cnt_q + CW'(1'b1);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q   <= REL_LVL;
            sync2_q   <= REL_LVL;
            db_q      <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_db      = db_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces WIDTH push-buttons into clean active-high levels and press/release pulses.
// Define BUTTON_DEBOUNCER_EVENT_LATCH_EN to add sticky, write-1-to-clear press flags.
module button_debouncer
    import button_pkg::*;
#(
    parameter int WIDTH      = BTN_WIDTH_DEF,
    parameter int CNT_MAX    = BTN_CNT_MAX_DEF,
    parameter int ACTIVE_LOW = BTN_ACTIVE_LOW_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_db,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release
`ifdef BUTTON_DEBOUNCER_EVENT_LATCH_EN
    ,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] btn_evt
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .CNT_MAX    (CNT_MAX),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_bit (
            .clk         (clk),
            .reset_n     (reset_n),
            .btn_raw     (btn_raw[i]),
            .btn_db      (btn_db[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

`ifdef BUTTON_DEBOUNCER_EVENT_LATCH_EN
    logic [WIDTH-1:0] evt_q, evt_d;

    // Set beats clear so a press landing on a clear strobe is never lost.
    always_comb begin
        evt_d = (evt_q & ~evt_clr) | btn_press;
    end

    // Sticky flag register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            evt_q <= {WIDTH{1'b0}};
        end else begin
            evt_q <= evt_d;
        end
    end

    assign btn_evt = evt_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (CNT_MAX=4, active-low pads, 8 buttons).
`timescale 1ns/1ps
module tb_button_debouncer;

    localparam int W  = 8;
    localparam int CM = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] btn_raw;
    logic [W-1:0] btn_db, btn_press, btn_release;
    logic [W-1:0] evt_clr;
`ifdef BUTTON_DEBOUNCER_EVENT_LATCH_EN
    logic [W-1:0] btn_evt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: pipe holds synchronised samples still in flight,
    // hist the most recent CM samples seen by the debouncer.
    logic [W-1:0] m_db, m_press, m_release, m_evt;
    logic [W-1:0] pipe[$];
    logic [W-1:0] hist[$];

    always #5 clk = ~clk;

    button_debouncer #(
        .WIDTH      (W),
        .CNT_MAX    (CM),
        .ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw     (btn_raw),
        .btn_db      (btn_db),
        .btn_press   (btn_press),
        .btn_release (btn_release)
`ifdef BUTTON_DEBOUNCER_EVENT_LATCH_EN
        ,
        .evt_clr     (evt_clr),
        .btn_evt     (btn_evt)
`endif
    );

    // Advance one clock edge, update the model from the inputs sampled there.
    task automatic step();
        logic [W-1:0] s, all_diff;
        @(posedge clk);
        if (!reset_n) begin
            m_db = {W{1'b0}}; m_press = {W{1'b0}}; m_release = {W{1'b0}}; m_evt = {W{1'b0}};
            pipe = {};
            pipe.push_back({W{1'b0}});
            pipe.push_back({W{1'b0}});
            hist = {};
        end else begin
            m_evt = (m_evt & ~evt_clr) | m_press;
            s = pipe.pop_front();
            pipe.push_back(~btn_raw);
            hist.push_back(s);
            if (hist.size() > CM) void'(hist.pop_front());
            all_diff = {W{1'b1}};
            foreach (hist[k]) all_diff &= hist[k] ^ m_db;
            if (hist.size() < CM) all_diff = {W{1'b0}};
            m_press   = all_diff & ~m_db;
            m_release = all_diff & m_db;
            m_db      = m_db ^ all_diff;
        end
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; btn_raw = 8'h00; evt_clr = 8'h00;
        settle(3);
        n_chk++; if (btn_db !== 8'h00) begin n_fail++; $display("FAIL reset_db: got %h expected 00", btn_db); end
        n_chk++; if (btn_press !== 8'h00) begin n_fail++; $display("FAIL reset_press: got %h expected 00", btn_press); end
        n_chk++; if (btn_release !== 8'h00) begin n_fail++; $display("FAIL reset_release: got %h expected 00", btn_release); end
`ifdef BUTTON_DEBOUNCER_EVENT_LATCH_EN
        n_chk++; if (btn_evt !== 8'h00) begin n_fail++; $display("FAIL reset_evt: got %h expected 00", btn_evt); end
`endif
        reset_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            n_chk++;
            if (btn_db !== ((i == 6) ? 8'hFF : 8'h00)) begin
                n_fail++; $display("FAIL held_through_reset_db edge %0d: got %h expected %h", i, btn_db, (i == 6) ? 8'hFF : 8'h00);
            end
        end
        n_chk++; if (btn_press !== 8'hFF) begin n_fail++; $display("FAIL held_through_reset_press: got %h expected ff", btn_press); end
        step();
        n_chk++; if (btn_press !== 8'h00) begin n_fail++; $display("FAIL press_width: got %h expected 00", btn_press); end
    endtask

    task automatic test_press_release();
        btn_raw = 8'hFF;
        settle(8);
        n_chk++; if (btn_db !== 8'h00) begin n_fail++; $display("FAIL all_released: got %h expected 00", btn_db); end
        btn_raw[0] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            n_chk++;
            if (btn_db[0] !== (i == 6) || btn_press[0] !== (i == 6)) begin
                n_fail++; $display("FAIL press0 edge %0d: got db=%b press=%b expected %b", i, btn_db[0], btn_press[0], (i == 6));
            end
        end
        btn_raw[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            n_chk++;
            if (btn_db[0] !== (i != 6) || btn_release[0] !== (i == 6)) begin
                n_fail++; $display("FAIL release0 edge %0d: got db=%b rel=%b expected db=%b rel=%b", i, btn_db[0], btn_release[0], (i != 6), (i == 6));
            end
        end
        step();
        n_chk++; if (btn_release[0] !== 1'b0) begin n_fail++; $display("FAIL release_width: got %b expected 0", btn_release[0]); end
    endtask

    task automatic test_glitch();
        logic seen;
        seen = 1'b0;
        btn_raw[3] = 1'b0;
        settle(3);
        btn_raw[3] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            seen = seen | btn_db[3] | btn_press[3] | btn_release[3];
        end
        n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL glitch3_rejected: got activity=%b expected 0", seen); end
        btn_raw[3] = 1'b0;
        settle(4);
        btn_raw[3] = 1'b1;
        settle(2);
        n_chk++; if (btn_db[3] !== 1'b1 || btn_press[3] !== 1'b1) begin
            n_fail++; $display("FAIL glitch4_accepted: got db=%b press=%b expected 1 1", btn_db[3], btn_press[3]);
        end
        settle(10);
        n_chk++; if (btn_db !== 8'h00) begin n_fail++; $display("FAIL glitch_restore: got %h expected 00", btn_db); end
    endtask

    task automatic test_simultaneous();
        btn_raw = 8'h5A;
        for (int i = 1; i <= 6; i++) begin
            step();
            n_chk++;
            if (btn_db !== ((i == 6) ? 8'hA5 : 8'h00) || btn_press !== ((i == 6) ? 8'hA5 : 8'h00)) begin
                n_fail++; $display("FAIL simultaneous edge %0d: got db=%h press=%h", i, btn_db, btn_press);
            end
        end
        btn_raw = 8'hFF;
        settle(8);
        n_chk++; if (btn_db !== 8'h00) begin n_fail++; $display("FAIL simultaneous_release: got %h expected 00", btn_db); end
    endtask

    task automatic test_reset_mid();
        btn_raw[1] = 1'b0;
        settle(4);
        reset_n = 1'b0;
        step();
        n_chk++; if (btn_db !== 8'h00) begin n_fail++; $display("FAIL midcount_reset_db: got %h expected 00", btn_db); end
        reset_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            n_chk++;
            if (btn_db[1] !== (i == 6)) begin
                n_fail++; $display("FAIL midcount_latency edge %0d: got %b expected %b", i, btn_db[1], (i == 6));
            end
        end
        btn_raw = 8'hFF;
        settle(8);
    endtask

`ifdef BUTTON_DEBOUNCER_EVENT_LATCH_EN
    task automatic test_event_latch();
        logic found;
        btn_raw[2] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin step(); found = btn_press[2]; end
        n_chk++; if (!found) begin n_fail++; $display("FAIL evt_first_press: got timeout expected press"); end
        settle(2);
        n_chk++; if (btn_evt[2] !== 1'b1) begin n_fail++; $display("FAIL evt_sticky: got %b expected 1", btn_evt[2]); end
        evt_clr[2] = 1'b1;
        step();
        evt_clr[2] = 1'b0;
        n_chk++; if (btn_evt[2] !== 1'b0) begin n_fail++; $display("FAIL evt_clear: got %b expected 0", btn_evt[2]); end
        btn_raw[2] = 1'b1;
        settle(8);
        btn_raw[2] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin step(); found = btn_press[2]; end
        n_chk++; if (!found) begin n_fail++; $display("FAIL evt_second_press: got timeout expected press"); end
        evt_clr[2] = 1'b1;
        step();
        evt_clr[2] = 1'b0;
        n_chk++; if (btn_evt[2] !== 1'b1) begin n_fail++; $display("FAIL evt_set_wins: got %b expected 1", btn_evt[2]); end
        evt_clr[2] = 1'b1;
        step();
        evt_clr[2] = 1'b0;
        n_chk++; if (btn_evt[2] !== 1'b0) begin n_fail++; $display("FAIL evt_lone_clear: got %b expected 0", btn_evt[2]); end
        btn_raw = 8'hFF;
        settle(8);
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            reset_n = ($urandom_range(0, 249) != 0);
            if ($urandom_range(0, 5) == 0) btn_raw = btn_raw ^ 8'($urandom);
            evt_clr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            step();
            n_chk++;
            if (btn_db !== m_db || btn_press !== m_press || btn_release !== m_release) begin
                n_fail++;
                $display("FAIL random cycle %0d: got db=%h p=%h r=%h expected db=%h p=%h r=%h",
                         c, btn_db, btn_press, btn_release, m_db, m_press, m_release);
            end
`ifdef BUTTON_DEBOUNCER_EVENT_LATCH_EN
            n_chk++;
            if (btn_evt !== m_evt) begin
                n_fail++; $display("FAIL random_evt cycle %0d: got %h expected %h", c, btn_evt, m_evt);
            end
`endif
        end
        reset_n = 1'b1;
        evt_clr = 8'h00;
    endtask

    initial begin
        reset_n = 1'b0;
        btn_raw = 8'h00;
        evt_clr = 8'h00;
        test_reset();
        test_press_release();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
`ifdef BUTTON_DEBOUNCER_EVENT_LATCH_EN
        test_event_latch();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
